// File: rtl/tone_key_controller_pkg.sv
// Shared constants for the PS/2 tone key controller: scan-code prefixes, the
// note key set, and the prefix parser state encoding.
package tone_key_controller_pkg;

  localparam logic [7:0] SC_BREAK   = 8'hF0;
  localparam logic [7:0] SC_EXT     = 8'hE0;
  localparam logic [7:0] SC_SILENCE = 8'h00;

  localparam int NUM_NOTES = 24;
  localparam logic [7:0] NOTE_CODES [NUM_NOTES] = '{
    8'h15, 8'h1d, 8'h24, 8'h2d, 8'h2c, 8'h35, 8'h3c, 8'h43,
    8'h44, 8'h4d, 8'h1c, 8'h1b, 8'h23, 8'h2b, 8'h34, 8'h33,
    8'h3b, 8'h42, 8'h4b, 8'h22, 8'h21, 8'h2a, 8'h32, 8'h31
  };

  typedef logic [1:0] pfx_state_t;
  localparam pfx_state_t PS_IDLE    = 2'd0;
  localparam pfx_state_t PS_BRK     = 2'd1;
  localparam pfx_state_t PS_EXT     = 2'd2;
  localparam pfx_state_t PS_EXT_BRK = 2'd3;

  function automatic logic is_note(input logic [7:0] b);
    is_note = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (NOTE_CODES[i] == b) is_note = 1'b1;
    end
  endfunction

endpackage

// File: rtl/tone_key_controller_if.sv
// Byte-receiver input and note-output bundle of the tone key controller.
// Handshake: rx_valid is a 1-cycle strobe qualifying rx_data; there is no ready,
// every strobed byte is consumed on the edge that samples it.
interface tone_key_controller_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] code_out;
  logic       gate;
  logic       note_chg;
  logic [3:0] held_cnt;
  logic       pfx_abort;
  logic [1:0] pfx_state;

  modport master (
    output rx_data, rx_valid,
    input  code_out, gate, note_chg, held_cnt, pfx_abort, pfx_state
  );

  modport slave (
    input  rx_data, rx_valid,
    output code_out, gate, note_chg, held_cnt, pfx_abort, pfx_state
  );
endinterface

// File: rtl/tone_key_controller_scan_prefix_fsm.sv
// Scan-code prefix parser: turns make / F0-break / E0-extended byte sequences into
// make and break strobes, and abandons a prefix whose follow-up byte never arrives.
module scan_prefix_fsm
  import tone_key_controller_pkg::*;
#(
  parameter int PFX_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       make_stb,
  output logic       brk_stb,
  output logic [7:0] code,
  output logic       pfx_abort,
  output logic [1:0] state
);

  localparam int CW = (PFX_TIMEOUT > 2) ? $clog2(PFX_TIMEOUT) : 1;

  pfx_state_t    state_q, state_d;
  logic [CW-1:0] tmo_q;
  logic          abort_d, abort_q;

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    if (rx_valid) begin
      case (state_q)
        PS_IDLE: begin
          if (rx_data == SC_BREAK)     state_d = PS_BRK;
          else if (rx_data == SC_EXT)  state_d = PS_EXT;
        end
        PS_EXT:  state_d = (rx_data == SC_BREAK) ? PS_EXT_BRK : PS_IDLE;
        default: state_d = PS_IDLE;
      endcase
    end else if (state_q != PS_IDLE && tmo_q == CW'(PFX_TIMEOUT - 1)) begin
      state_d = PS_IDLE;
      abort_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
      tmo_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      // Counter only runs while a prefix is pending and no byte arrives.
      if (rx_valid || abort_d || state_q == PS_IDLE) tmo_q <= '0;
      else                                           tmo_q <= tmo_q + 1'b1;
    end
  end

  assign make_stb  = rx_valid && (state_q == PS_IDLE) && is_note(rx_data);
  assign brk_stb   = rx_valid && (state_q == PS_BRK);
  assign code      = rx_data;
  assign pfx_abort = abort_q;
  assign state     = state_q;

endmodule

// File: rtl/tone_key_controller.sv
// Held-note stack with last-pressed priority driving the sine generator note code;
// released keys fall back to the most recent still-held key, empty stack is silence.
module tone_key_controller
  import tone_key_controller_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int PFX_TIMEOUT = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tone_key_controller_if.slave  bus
);

  logic       make_stb, brk_stb;
  logic [7:0] ev_code;

  scan_prefix_fsm #(.PFX_TIMEOUT(PFX_TIMEOUT)) u_prefix (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (bus.rx_data),
    .rx_valid  (bus.rx_valid),
    .make_stb  (make_stb),
    .brk_stb   (brk_stb),
    .code      (ev_code),
    .pfx_abort (bus.pfx_abort),
    .state     (bus.pfx_state)
  );

  // stk_q[0] is the oldest held key, stk_q[cnt_q-1] the sounding one.
  logic [7:0] stk_q [DEPTH];
  logic [7:0] stk_d [DEPTH];
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] top_d, code_q;
  logic       gate_q, chg_q;
  logic       found;
  logic [3:0] pos;

  always_comb begin
    stk_d = stk_q;
    cnt_d = cnt_q;
    found = 1'b0;
    pos   = '0;
    top_d = SC_SILENCE;
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) < cnt_q && stk_q[i] == ev_code) begin
        found = 1'b1;
        pos   = 4'(i);
      end
    end
    if (make_stb && !found) begin
      if (cnt_q < 4'(DEPTH)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (4'(i) == cnt_q) stk_d[i] = ev_code;
        end
        cnt_d = cnt_q + 4'd1;
      end else begin
        for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i + 1];
        stk_d[DEPTH-1] = ev_code;
      end
    end else if (brk_stb && found) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (4'(i) >= pos) stk_d[i] = stk_q[i + 1];
      end
      stk_d[DEPTH-1] = SC_SILENCE;
      cnt_d = cnt_q - 4'd1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_d == 4'(i + 1)) top_d = stk_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= SC_SILENCE;
      cnt_q  <= '0;
      code_q <= SC_SILENCE;
      gate_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      stk_q  <= stk_d;
      cnt_q  <= cnt_d;
      code_q <= top_d;
      gate_q <= (cnt_d != 4'd0);
      chg_q  <= (top_d != code_q);
    end
  end

  assign bus.code_out = code_q;
  assign bus.gate     = gate_q;
  assign bus.note_chg = chg_q;
  assign bus.held_cnt = cnt_q;

endmodule

// File: tb/tb_tone_key_controller.sv
// Bench for tone_key_controller: vector table, hand-written multi-cycle corners,
// and a randomised phase against a queue-based held-key model.
module tb_tone_key_controller;

  localparam int DEPTH = 4;
  localparam int T     = 20;
  localparam int W     = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tone_key_controller_if bus();

  tone_key_controller #(.DEPTH(DEPTH), .PFX_TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errs   = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [7:0] b;
    logic [7:0] c;
    logic       g;
    logic       ch;
    logic [3:0] h;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [W-1:0] pk(logic ab, logic [7:0] c, logic g, logic ch, logic [3:0] h);
    return {ab, c, g, ch, h};
  endfunction

  function automatic logic [W-1:0] act_out();
    return {bus.pfx_abort, bus.code_out, bus.gate, bus.note_chg, bus.held_cnt};
  endfunction

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard: pop the oldest expectation and compare against the outputs
  task automatic check_out(input string name);
    logic [W-1:0] e, a;
    checks++;
    a = act_out();
    if (exp_q.size() == 0) begin
      errs++;
      $display("FAIL %s: scoreboard empty, got %h", name, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errs++;
        $display("FAIL %s: got abort=%b code=%h gate=%b chg=%b held=%0d expected abort=%b code=%h gate=%b chg=%b held=%0d",
                 name, a[14], a[13:6], a[5], a[4], a[3:0], e[14], e[13:6], e[5], e[4], e[3:0]);
      end
    end
  endtask

  // driver: present one byte for one edge, then compare the registered result
  task automatic send(input logic [7:0] b, input logic [W-1:0] e, input string name);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    check_out(name);
  endtask

  task automatic add(input logic [7:0] b, input logic [7:0] c, input logic g,
                     input logic ch, input logic [3:0] h);
    vec_t v;
    v.b = b; v.c = c; v.g = g; v.ch = ch; v.h = h;
    vecs.push_back(v);
  endtask

  // reference model for the random phase
  logic [7:0] m_stk[$];
  int         m_st;

  function automatic logic m_is_note(logic [7:0] b);
    return (b == 8'h15 || b == 8'h1d || b == 8'h24 || b == 8'h2d || b == 8'h2c || b == 8'h35);
  endfunction

  function automatic logic [7:0] m_top();
    return (m_stk.size() == 0) ? 8'h00 : m_stk[m_stk.size() - 1];
  endfunction

  function automatic logic [W-1:0] m_step(logic [7:0] b);
    logic [7:0] old_top;
    int idx;
    old_top = m_top();
    idx = -1;
    foreach (m_stk[i]) if (m_stk[i] == b) idx = i;
    case (m_st)
      0: begin
        if (b == 8'hF0) m_st = 1;
        else if (b == 8'hE0) m_st = 2;
        else if (m_is_note(b) && idx < 0) begin
          if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
          m_stk.push_back(b);
        end
      end
      1: begin
        if (idx >= 0) m_stk.delete(idx);
        m_st = 0;
      end
      2: m_st = (b == 8'hF0) ? 3 : 0;
      default: m_st = 0;
    endcase
    return pk(1'b0, m_top(), m_stk.size() != 0, m_top() != old_top, 4'(m_stk.size()));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int at;
    logic [7:0] pool [10];
    pool = '{8'h15, 8'h1d, 8'h24, 8'h2d, 8'h2c, 8'h35, 8'hF0, 8'hF0, 8'hE0, 8'h5A};

    // A: single note on/off
    add(8'h15, 8'h15, 1, 1, 1); add(8'hF0, 8'h15, 1, 0, 1); add(8'h15, 8'h00, 0, 1, 0);
    // B: fallback and release of a non-top key
    add(8'h15, 8'h15, 1, 1, 1); add(8'h1d, 8'h1d, 1, 1, 2); add(8'h24, 8'h24, 1, 1, 3);
    add(8'hF0, 8'h24, 1, 0, 3); add(8'h24, 8'h1d, 1, 1, 2);
    add(8'hF0, 8'h1d, 1, 0, 2); add(8'h15, 8'h1d, 1, 0, 1);
    add(8'hF0, 8'h1d, 1, 0, 1); add(8'h1d, 8'h00, 0, 1, 0);
    // C: full stack drops the oldest key
    add(8'h15, 8'h15, 1, 1, 1); add(8'h1d, 8'h1d, 1, 1, 2); add(8'h24, 8'h24, 1, 1, 3);
    add(8'h2d, 8'h2d, 1, 1, 4); add(8'h2c, 8'h2c, 1, 1, 4);
    add(8'hF0, 8'h2c, 1, 0, 4); add(8'h2c, 8'h2d, 1, 1, 3);
    add(8'hF0, 8'h2d, 1, 0, 3); add(8'h15, 8'h2d, 1, 0, 3);
    add(8'hF0, 8'h2d, 1, 0, 3); add(8'h2d, 8'h24, 1, 1, 2);
    add(8'hF0, 8'h24, 1, 0, 2); add(8'h24, 8'h1d, 1, 1, 1);
    add(8'hF0, 8'h1d, 1, 0, 1); add(8'h1d, 8'h00, 0, 1, 0);
    // D: typematic repeat, extended break, non-note byte, F0 F0
    add(8'h15, 8'h15, 1, 1, 1); add(8'h15, 8'h15, 1, 0, 1); add(8'h15, 8'h15, 1, 0, 1);
    add(8'hE0, 8'h15, 1, 0, 1); add(8'hF0, 8'h15, 1, 0, 1); add(8'h15, 8'h15, 1, 0, 1);
    add(8'h5A, 8'h15, 1, 0, 1);
    add(8'hF0, 8'h15, 1, 0, 1); add(8'h15, 8'h00, 0, 1, 0);
    add(8'hF0, 8'h00, 0, 0, 0); add(8'hF0, 8'h00, 0, 0, 0); add(8'h1d, 8'h1d, 1, 1, 1);
    add(8'hF0, 8'h1d, 1, 0, 1); add(8'h1d, 8'h00, 0, 1, 0);

    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(pk(0, 8'h00, 0, 0, 0));
    check_out("reset");
    check_val("reset_state", int'(bus.pfx_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      send(vecs[i].b, pk(1'b0, vecs[i].c, vecs[i].g, vecs[i].ch, vecs[i].h), $sformatf("vec%0d", i));

    // reset while a break prefix is pending
    send(8'h15, pk(0, 8'h15, 1, 1, 1), "mid_make");
    send(8'hF0, pk(0, 8'h15, 1, 0, 1), "mid_brk");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.push_back(pk(0, 8'h00, 0, 0, 0));
    check_out("rst_mid");
    check_val("rst_mid_state", int'(bus.pfx_state), 0);
    rst_n = 1'b1;
    send(8'h2d, pk(0, 8'h2d, 1, 1, 1), "after_rst_make");
    send(8'hF0, pk(0, 8'h2d, 1, 0, 1), "after_rst_f0");
    send(8'h2d, pk(0, 8'h00, 0, 1, 0), "after_rst_brk");

    // prefix timeout
    send(8'hF0, pk(0, 8'h00, 0, 0, 0), "tmo_f0");
    at = 0;
    for (int k = 1; k <= T + 4 && at == 0; k++) begin
      @(negedge clk);
      if (bus.pfx_abort) at = k;
    end
    check_val("tmo_cycle", at, T);
    check_val("tmo_state", int'(bus.pfx_state), 0);
    @(negedge clk);
    check_val("tmo_pulse_width", int'(bus.pfx_abort), 0);
    send(8'h15, pk(0, 8'h15, 1, 1, 1), "tmo_then_make");

    // byte arriving on the timeout edge is taken as the break target
    send(8'hF0, pk(0, 8'h15, 1, 0, 1), "race_f0");
    repeat (T - 1) @(negedge clk);
    send(8'h15, pk(0, 8'h00, 0, 1, 0), "race_brk");

    // random traffic against the model
    m_stk.delete();
    m_st = 0;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] b;
      b = pool[$urandom_range(0, 9)];
      send(b, m_step(b), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
